// File: rtl/stream_downsizer_if.sv
// Word-in / chunk-out stream bundle for stream_downsizer.
// Handshake: a transfer happens on a rising edge where valid && ready; IN_valid/IN_data/IN_cnt and OUT_valid/OUT_data/OUT_last hold until taken.
interface stream_downsizer_if #(
  parameter int IN_WIDTH  = 32,
  parameter int OUT_WIDTH = 8,
  parameter int CNT_W     = $clog2(IN_WIDTH / OUT_WIDTH)
);
  logic [IN_WIDTH-1:0]  IN_data;
  logic [CNT_W-1:0]     IN_cnt;
  logic                 IN_valid;
  logic                 OUT_ready;
  logic                 IN_ready;
  logic                 OUT_valid;
  logic [OUT_WIDTH-1:0] OUT_data;
  logic                 OUT_last;

  modport master (
    output IN_data, IN_cnt, IN_valid, IN_ready,
    input  OUT_ready, OUT_valid, OUT_data, OUT_last
  );

  modport slave (
    input  IN_data, IN_cnt, IN_valid, IN_ready,
    output OUT_ready, OUT_valid, OUT_data, OUT_last
  );
endinterface

// File: rtl/stream_downsizer.sv
// Splits each IN_WIDTH word into OUT_WIDTH chunks, LSB chunk first, honouring a per-word chunk count.
// Sustains one chunk per cycle across word boundaries by reloading on the last-chunk handshake.
module stream_downsizer #(
  parameter int IN_WIDTH  = 32,
  parameter int OUT_WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  stream_downsizer_if.slave   bus,
  output logic                dbg_state
);
  localparam int RATIO = IN_WIDTH / OUT_WIDTH;
  localparam int CNT_W = $clog2(RATIO);

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t               state_q, state_d;
  logic [IN_WIDTH-1:0]  hold_q, hold_d;
  logic [CNT_W-1:0]     idx_q, idx_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  logic                 out_valid;
  logic                 out_last;
  logic                 out_ready;
  logic [OUT_WIDTH-1:0] chunk;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      hold_q  <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  // Chunk select written as an explicit mux so idx never needs widening.
  always_comb begin
    chunk = '0;
    for (int i = 0; i < RATIO; i++) begin
      if (idx_q == i[CNT_W-1:0]) chunk = hold_q[i*OUT_WIDTH +: OUT_WIDTH];
    end
  end

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_ready = 1'b0;

    case (state_q)
      IDLE: begin
        out_ready = 1'b1;
        if (bus.IN_valid) begin
          hold_d  = bus.IN_data;
          cnt_d   = bus.IN_cnt;
          idx_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        out_valid = 1'b1;
        out_last  = (idx_q == cnt_q);
        out_ready = out_last && bus.IN_ready;
        if (bus.IN_ready) begin
          if (!out_last) begin
            idx_d = idx_q + 1'b1;
          end else if (bus.IN_valid) begin
            hold_d = bus.IN_data;
            cnt_d  = bus.IN_cnt;
            idx_d  = '0;
          end else begin
            idx_d   = '0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset must block the upstream FIFO from popping a word we would discard.
  assign bus.OUT_ready = out_ready && rst;
  assign bus.OUT_valid = out_valid;
  assign bus.OUT_last  = out_last;
  assign bus.OUT_data  = out_valid ? chunk : '0;
  assign dbg_state     = state_q;
endmodule

// File: tb/tb_stream_downsizer.sv
// Directed bench for stream_downsizer: each task drives one scenario cycle by cycle and checks outputs inline.
module tb_stream_downsizer;
  logic clk;
  logic rst;
  logic dbg_state;
  int   tests_run;
  int   tests_failed;

  stream_downsizer_if #(.IN_WIDTH(32), .OUT_WIDTH(8)) bus ();

  stream_downsizer #(.IN_WIDTH(32), .OUT_WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change on the falling edge; outputs are looked at 1ns later.
  task automatic drive(input logic r, input logic v, input logic [31:0] d,
                       input logic [1:0] c, input logic rdy);
    @(negedge clk);
    rst          = r;
    bus.IN_valid = v;
    bus.IN_data  = d;
    bus.IN_cnt   = c;
    bus.IN_ready = rdy;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; bus.IN_valid = 1'b1; bus.IN_data = 32'h12345678;
    bus.IN_cnt = 2'd3; bus.IN_ready = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 32'h12345678, 2'd3, 1'b1);
      tests_run++;
      if (bus.OUT_ready !== 1'b0 || bus.OUT_valid !== 1'b0 ||
          bus.OUT_data !== 8'h00 || bus.OUT_last !== 1'b0) begin
        tests_failed++;
        $display("FAIL reset_hold[%0d] got rdy=%b vld=%b data=%h last=%b exp 0 0 00 0",
                 i, bus.OUT_ready, bus.OUT_valid, bus.OUT_data, bus.OUT_last);
      end
    end
    drive(1'b1, 1'b0, 32'h0, 2'd0, 1'b1);
    tests_run++;
    if (bus.OUT_ready !== 1'b1 || bus.OUT_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_release got rdy=%b vld=%b exp 1 0", bus.OUT_ready, bus.OUT_valid);
    end
    drive(1'b1, 1'b0, 32'h0, 2'd0, 1'b1);
    tests_run++;
    if (bus.OUT_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_no_consume got vld=%b exp 0", bus.OUT_valid);
    end
  endtask

  task automatic test_full_word();
    logic [7:0] exp_d [4];
    exp_d = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    drive(1'b1, 1'b1, 32'hDEADBEEF, 2'd3, 1'b1);
    tests_run++;
    if (bus.OUT_ready !== 1'b1 || bus.OUT_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL full_accept got rdy=%b vld=%b exp 1 0", bus.OUT_ready, bus.OUT_valid);
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 32'h0, 2'd0, 1'b1);
      tests_run++;
      if (bus.OUT_valid !== 1'b1 || bus.OUT_data !== exp_d[i] ||
          bus.OUT_last !== (i == 3) || bus.OUT_ready !== (i == 3)) begin
        tests_failed++;
        $display("FAIL full_chunk[%0d] got vld=%b data=%h last=%b rdy=%b exp 1 %h %b %b",
                 i, bus.OUT_valid, bus.OUT_data, bus.OUT_last, bus.OUT_ready,
                 exp_d[i], (i == 3), (i == 3));
      end
    end
    drive(1'b1, 1'b0, 32'h0, 2'd0, 1'b1);
    tests_run++;
    if (bus.OUT_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL full_idle_after got vld=%b exp 0", bus.OUT_valid);
    end
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 1'b1, 32'h03020100, 2'd3, 1'b1);
    for (int i = 0; i < 8; i++) begin
      if (i < 4) drive(1'b1, 1'b1, 32'h07060504, 2'd3, 1'b1);
      else       drive(1'b1, 1'b0, 32'h0, 2'd0, 1'b1);
      tests_run++;
      if (bus.OUT_valid !== 1'b1 || bus.OUT_data !== i[7:0] ||
          bus.OUT_last !== (i == 3 || i == 7) || bus.OUT_ready !== (i == 3 || i == 7)) begin
        tests_failed++;
        $display("FAIL b2b_chunk[%0d] got vld=%b data=%h last=%b rdy=%b exp 1 %h %b %b",
                 i, bus.OUT_valid, bus.OUT_data, bus.OUT_last, bus.OUT_ready,
                 i[7:0], (i == 3 || i == 7), (i == 3 || i == 7));
      end
    end
    drive(1'b1, 1'b0, 32'h0, 2'd0, 1'b1);
    tests_run++;
    if (bus.OUT_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_idle_after got vld=%b exp 0", bus.OUT_valid);
    end
  endtask

  task automatic test_partial();
    logic [7:0] exp_d [3];
    logic       exp_l [3];
    exp_d = '{8'hAA, 8'hBB, 8'hCC};
    exp_l = '{1'b1, 1'b0, 1'b1};
    drive(1'b1, 1'b1, 32'h000000AA, 2'd0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      if (i == 0) drive(1'b1, 1'b1, 32'h0000CCBB, 2'd1, 1'b1);
      else        drive(1'b1, 1'b0, 32'h0, 2'd0, 1'b1);
      tests_run++;
      if (bus.OUT_valid !== 1'b1 || bus.OUT_data !== exp_d[i] || bus.OUT_last !== exp_l[i]) begin
        tests_failed++;
        $display("FAIL partial_chunk[%0d] got vld=%b data=%h last=%b exp 1 %h %b",
                 i, bus.OUT_valid, bus.OUT_data, bus.OUT_last, exp_d[i], exp_l[i]);
      end
    end
    drive(1'b1, 1'b0, 32'h0, 2'd0, 1'b1);
    tests_run++;
    if (bus.OUT_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL partial_idle_after got vld=%b exp 0", bus.OUT_valid);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] exp_d [7];
    logic       rdy   [7];
    exp_d = '{8'h44, 8'h33, 8'h33, 8'h33, 8'h33, 8'h22, 8'h11};
    rdy   = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    drive(1'b1, 1'b1, 32'h11223344, 2'd3, 1'b1);
    for (int i = 0; i < 7; i++) begin
      // A competing word is offered during the stall and must be ignored.
      if (!rdy[i]) drive(1'b1, 1'b1, 32'h99999999, 2'd0, 1'b0);
      else         drive(1'b1, 1'b0, 32'h0, 2'd0, 1'b1);
      tests_run++;
      if (bus.OUT_valid !== 1'b1 || bus.OUT_data !== exp_d[i] ||
          bus.OUT_last !== (i == 6) || bus.OUT_ready !== (i == 6)) begin
        tests_failed++;
        $display("FAIL bp_chunk[%0d] got vld=%b data=%h last=%b rdy=%b exp 1 %h %b %b",
                 i, bus.OUT_valid, bus.OUT_data, bus.OUT_last, bus.OUT_ready,
                 exp_d[i], (i == 6), (i == 6));
      end
    end
    drive(1'b1, 1'b0, 32'h0, 2'd0, 1'b1);
    tests_run++;
    if (bus.OUT_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_idle_after got vld=%b exp 0", bus.OUT_valid);
    end
  endtask

  task automatic test_reset_mid_word();
    logic [7:0] exp_d [2];
    exp_d = '{8'h0D, 8'hF0};
    drive(1'b1, 1'b1, 32'hCAFEF00D, 2'd3, 1'b1);
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b0, 32'h0, 2'd0, 1'b1);
      tests_run++;
      if (bus.OUT_valid !== 1'b1 || bus.OUT_data !== exp_d[i]) begin
        tests_failed++;
        $display("FAIL rmw_chunk[%0d] got vld=%b data=%h exp 1 %h",
                 i, bus.OUT_valid, bus.OUT_data, exp_d[i]);
      end
    end
    drive(1'b0, 1'b1, 32'h0, 2'd0, 1'b1);
    tests_run++;
    if (bus.OUT_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL rmw_ready_in_reset got rdy=%b exp 0", bus.OUT_ready);
    end
    drive(1'b1, 1'b1, 32'h000000FF, 2'd0, 1'b1);
    tests_run++;
    if (bus.OUT_valid !== 1'b0 || bus.OUT_ready !== 1'b1 ||
        bus.OUT_data !== 8'h00 || bus.OUT_last !== 1'b0) begin
      tests_failed++;
      $display("FAIL rmw_after_reset got vld=%b rdy=%b data=%h last=%b exp 0 1 00 0",
               bus.OUT_valid, bus.OUT_ready, bus.OUT_data, bus.OUT_last);
    end
    drive(1'b1, 1'b0, 32'h0, 2'd0, 1'b1);
    tests_run++;
    if (bus.OUT_valid !== 1'b1 || bus.OUT_data !== 8'hFF || bus.OUT_last !== 1'b1) begin
      tests_failed++;
      $display("FAIL rmw_new_word got vld=%b data=%h last=%b exp 1 ff 1",
               bus.OUT_valid, bus.OUT_data, bus.OUT_last);
    end
    drive(1'b1, 1'b0, 32'h0, 2'd0, 1'b1);
    tests_run++;
    if (bus.OUT_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL rmw_idle_after got vld=%b exp 0", bus.OUT_valid);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_full_word();
    test_back_to_back();
    test_partial();
    test_backpressure();
    test_reset_mid_word();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
